rns_rev_conv_mrc_32_17_13_11: RTL and testbench
===============================================

Name: rns_rev_conv_mrc_32_17_13_11

Overview:
Reverse converter for the {32,17,13,11} residue number system. It rebuilds the binary integer X from its four residues using sequential mixed-radix conversion (MRC), one digit per clock. It sits at the output of the RNS datapath, after the per-modulus forward reducers and channel arithmetic. Dynamic range is M = 77792, so the 17-bit output covers every 16-bit forward-converted operand.

Parameters:
OUT_W, 17, output width; fixed at ceil(log2(77792)), other values unsupported.
CHECK_RANGE, 1, 1 = detect non-canonical residues and flag them; 0 = skip detection, out_err tied 0.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  residue set valid.
in_ready  output  1  converter can accept a residue set.
r32  input  5  X mod 32.
r17  input  5  X mod 17, canonical 0..16.
r13  input  4  X mod 13, canonical 0..12.
r11  input  4  X mod 11, canonical 0..10.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_x  output  OUT_W  reconstructed X, 0..77791.
out_err  output  1  at least one residue was out of range.

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1, out_valid=0, out_x=0, out_err=0, internal digit registers cleared.
- MRC constants, decided:
  - a1 = r32
  - a2 = ((r17 - a1)·8) mod 17
  - a3 = ((((r13 - a1)·11) - a2)·10) mod 13
  - a4 = (((((r11 - a1)·10) - a2)·2) - a3)·6) mod 11
  - X = a1 + 32·a2 + 544·a3 + 7072·a4
- Modular arithmetic rules:
  - Subtraction is performed modulo m, with a conditional add of m on borrow.
  - Before any subtraction, a1 and a2 are reduced modulo the target modulus.
  - Multiplication by a constant is followed by full reduction to [0, m-1].
  - No intermediate value may wrap.
- FSM: IDLE → A2 → A3 → A4 → SUM → OUT → IDLE.
  - IDLE: in_ready=1. On in_valid&in_ready, register all residues and a1, latch the range-error flag, go to A2.
  - A2: compute and store a2.
  - A3: compute and store a3.
  - A4: compute and store a4.
  - SUM: compute and store X.
  - OUT: out_valid=1; out_x and out_err held stable.
- Latency: out_valid rises exactly 4 clock edges after the accept edge.
- Output handshake:
  - out_valid stays high until out_ready is sampled high. The next edge then goes to IDLE and drops out_valid.
  - out_x keeps its last value after release.
- in_ready is 0 in every state except IDLE, so there is no overlap. Throughput is at most one conversion per 6 cycles. in_valid is ignored outside IDLE.
- Range error (CHECK_RANGE=1), raised when r17>16, r13>12 or r11>10:
  - out_err=1 and out_x=0 for that transaction.
  - The FSM still traverses all states, so latency is unchanged.
- rst asserted in any state aborts the conversion immediately and returns all outputs to reset values. No partial result is ever presented.
- The output value is purely a function of the accepted residues. Input changes after acceptance have no effect.

Test Plan:
- Reset then (r32,r17,r13,r11)=(25,3,8,3), out_ready=1 → digits a2=11, a3=9, a4=1; out_x=12345, out_err=0; out_valid exactly 4 edges after accept, in_ready low during conversion.
- Corner values:
  - (0,0,0,0) → out_x=0.
  - (31,0,2,8) → out_x=65535.
  - (31,16,12,10) → out_x=77791.
- Backpressure: result 12345 with out_ready=0 for 10 cycles → out_valid and out_x held stable, in_ready=0 throughout; out_ready=1 → out_valid drops the next edge, in_ready=1.
- Range error: r17=20 with other residues legal → out_err=1, out_x=0, latency still 4. Next legal set (25,3,8,3) → out_err=0, out_x=12345.
- Mid-conversion reset: assert rst asynchronously while in A3 → out_valid=0 and in_ready=1 immediately. After release, a new set converts correctly.
- Random sweep: 2000 random X in 0..77791, residues from the golden model, random in_valid/out_ready gaps → every out_x equals X, and no transaction is lost or duplicated.

Source files
------------

// File: rtl/rns_rev_conv_mrc_32_17_13_11.sv
// rns_rev_conv_mrc_32_17_13_11: sequential MRC reverse converter for the {32,17,13,11} RNS, one digit per clock.
module rns_rev_conv_mrc_32_17_13_11 #(
  parameter int OUT_W       = 17,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       r32,
  input  logic [4:0]       r17,
  input  logic [3:0]       r13,
  input  logic [3:0]       r11,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_x,
  output logic             out_err
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] A2   = 3'd1;
  localparam logic [2:0] A3   = 3'd2;
  localparam logic [2:0] A4   = 3'd3;
  localparam logic [2:0] SUM  = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;

  logic [2:0]       state;
  logic [4:0]       a1, a2, r17_q;
  logic [3:0]       a3, a4, r13_q, r11_q;
  logic             err_q, in_err;
  logic [4:0]       a2_n;
  logic [3:0]       a3_n, a4_n;
  logic [OUT_W-1:0] x_n;

  // Operands are reduced first so non-canonical residues never wrap the borrow add.
  function automatic logic [7:0] sub_m(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    logic [7:0] ar, br;
    ar = a % m;
    br = b % m;
    return (ar >= br) ? ar - br : ar + m - br;
  endfunction

  function automatic logic [7:0] mul_m(input logic [7:0] a, input logic [7:0] k, input logic [7:0] m);
    return (a * k) % m;
  endfunction

  assign in_err = CHECK_RANGE && (r17 > 5'd16 || r13 > 4'd12 || r11 > 4'd10);
  assign a2_n = 5'(mul_m(sub_m(8'(r17_q), 8'(a1), 8'd17), 8'd8, 8'd17));
  assign a3_n = 4'(mul_m(sub_m(mul_m(sub_m(8'(r13_q), 8'(a1), 8'd13), 8'd11, 8'd13),
                               8'(a2), 8'd13), 8'd10, 8'd13));
  assign a4_n = 4'(mul_m(sub_m(mul_m(sub_m(mul_m(sub_m(8'(r11_q), 8'(a1), 8'd11), 8'd10, 8'd11),
                                           8'(a2), 8'd11), 8'd2, 8'd11),
                               8'(a3), 8'd11), 8'd6, 8'd11));
  assign x_n = err_q ? '0 : OUT_W'(a1) + OUT_W'(a2) * OUT_W'(32) + OUT_W'(a3) * OUT_W'(544)
                          + OUT_W'(a4) * OUT_W'(7072);
  assign in_ready  = state == IDLE;
  assign out_valid = state == OUT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a1      <= '0;
      a2      <= '0;
      a3      <= '0;
      a4      <= '0;
      r17_q   <= '0;
      r13_q   <= '0;
      r11_q   <= '0;
      err_q   <= 1'b0;
      out_x   <= '0;
      out_err <= 1'b0;
    end else begin
      state <= (state == IDLE) ? (in_valid ? A2 : IDLE)
             : (state == OUT)  ? (out_ready ? IDLE : OUT)
             : state + 3'd1;
      if (state == IDLE && in_valid) begin
        a1    <= r32;
        r17_q <= r17;
        r13_q <= r13;
        r11_q <= r11;
        err_q <= in_err;
      end
      if (state == A2) a2 <= a2_n;
      if (state == A3) a3 <= a3_n;
      if (state == A4) a4 <= a4_n;
      if (state == SUM) begin
        out_x   <= x_n;
        out_err <= err_q;
      end
    end
  end
endmodule

// File: tb/tb_rns_rev_conv_mrc_32_17_13_11.sv
// tb_rns_rev_conv_mrc_32_17_13_11: scoreboard bench; expected X comes from the integer being encoded.
module tb_rns_rev_conv_mrc_32_17_13_11;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, out_err;
  logic [4:0]  r32 = 0, r17 = 0;
  logic [3:0]  r13 = 0, r11 = 0;
  logic [16:0] out_x;
  int vectors = 0, miscompares = 0, checks = 0, cyc = 0, rdy_mode = 0;

  typedef struct {int x; bit err; int acc;} exp_t;
  exp_t q[$];
  exp_t me;
  bit hold = 0, rel = 0;
  logic [16:0] hx;
  logic he;

  rns_rev_conv_mrc_32_17_13_11 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r32(r32), .r17(r17), .r13(r13), .r11(r11),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 1) ? ($urandom_range(0, 9) < 7) : (rdy_mode == 0);
  end

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares on every output handshake, plus hold, latency and release rules.
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      rel  = 0;
    end else begin
      if (rel) chk(!out_valid && in_ready, "release", out_valid, 0);
      if (hold) chk(out_valid && out_x == hx && out_err == he, "hold_stable", out_x, hx);
      if (out_valid && !hold && q.size() > 0) chk(cyc - q[0].acc == 4, "latency", cyc - q[0].acc, 4);
      if (out_valid) chk(!in_ready, "in_ready_busy", in_ready, 0);
      rel = out_valid && out_ready;
      if (rel) begin
        if (q.size() == 0) chk(0, "unexpected_output", out_x, -1);
        else begin
          me = q.pop_front();
          chk(out_x == 17'(me.x), "out_x", out_x, me.x);
          chk(out_err == me.err, "out_err", out_err, me.err);
        end
      end
      hold = out_valid && !out_ready;
      hx = out_x;
      he = out_err;
    end
  end

  task automatic send(input int x, input int a, input int b, input int c, input int d, input bit bad);
    int n = 0;
    exp_t e;
    e.x = x;
    e.err = bad;
    @(negedge clk);
    r32 = 5'(a); r17 = 5'(b); r13 = 4'(c); r11 = 4'(d);
    in_valid = 1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk(0, "accept_timeout", n, 100);
      in_valid = 0;
      return;
    end
    e.acc = cyc + 1;
    q.push_back(e);
    vectors++;
    @(posedge clk);
    #1 in_valid = 0;
    r32 = 5'($urandom); r17 = 5'($urandom); r13 = 4'($urandom); r11 = 4'($urandom);
    chk(!in_ready, "in_ready_after_accept", in_ready, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk(0, "drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int x, n;
    #12;
    chk(in_ready && !out_valid, "reset_handshake", {in_ready, out_valid}, 2);
    chk(out_x == 0 && !out_err, "reset_out", out_x, 0);
    @(negedge clk) rst = 0;
    send(12345, 25, 3, 8, 3, 0);
    drain();
    send(0, 0, 0, 0, 0, 0);
    send(65535, 31, 0, 2, 8, 0);
    send(77791, 31, 16, 12, 10, 0);
    drain();
    rdy_mode = 2;
    send(12345, 25, 3, 8, 3, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(out_valid, "bp_valid_timeout", out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      chk(out_valid && !in_ready && out_x == 17'd12345, "bp_hold", out_x, 12345);
    end
    rdy_mode = 0;
    drain();
    chk(in_ready && !out_valid, "bp_released", in_ready, 1);
    send(0, 25, 20, 8, 3, 1);
    send(12345, 25, 3, 8, 3, 0);
    drain();
    send(12345, 25, 3, 8, 3, 0);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk(!out_valid && in_ready, "async_reset_hs", {out_valid, in_ready}, 1);
    chk(out_x == 0 && !out_err, "async_reset_out", out_x, 0);
    q.delete();
    @(negedge clk) rst = 0;
    send(65535, 31, 0, 2, 8, 0);
    drain();
    rdy_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      x = int'($urandom_range(0, 77791));
      send(x, x % 32, x % 17, x % 13, x % 11, 0);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
